// File: rtl/gan_sched_pkg.sv
// ----------------------------------------------------------------------------
// gan_sched_pkg
//
// Purpose:
//   Shared definitions for the generator-chain layer scheduler: the FSM state
//   encoding, default sizing values and a small helper for sizing the
//   watchdog timer.
//
// Contents:
//   sched_state_t            ST_IDLE=2'd0, ST_RUN=2'd1, ST_ERR=2'd2
//   DEFAULT_NUM_LAYERS       number of sequenced layers
//   DEFAULT_IDX_W            width of the current-layer index
//   DEFAULT_TIMEOUT_CYCLES   per-layer watchdog limit
//   DEFAULT_CNT_W            width of the run cycle counter
//   timer_width()            bits needed to hold 0..limit inclusive
// ----------------------------------------------------------------------------
package gan_sched_pkg;

    // Scheduler states. ST_ERR is only reachable when the watchdog is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } sched_state_t;

    localparam int DEFAULT_NUM_LAYERS     = 3;
    localparam int DEFAULT_IDX_W          = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 131072;
    localparam int DEFAULT_CNT_W          = 32;

    // The watchdog counter has to be able to reach the limit value itself,
    // so it needs one more code than clog2(limit) alone would give.
    function automatic int timer_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/gan_sched_watchdog.sv
// ----------------------------------------------------------------------------
// gan_sched_watchdog
//
// Purpose:
//   Per-layer stall timer for the layer scheduler. Only instantiated when the
//   scheduler is built with GAN_SCHED_WATCHDOG_EN defined.
//   The count restarts on every layer launch and advances once per cycle while
//   the scheduler waits for the running layer. Once it reaches TIMEOUT_CYCLES
//   it stops there and holds timeout high until the next clear.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles a layer may wait before timeout is raised
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   restart the count (a layer is being launched)
//   enable   in   count this cycle (scheduler is running)
//   timeout  out  count has reached TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module gan_sched_watchdog
    import gan_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int            TW    = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count;

    // Wait-cycle counter. A launch always wins over counting so the new layer
    // starts from zero; the count parks at the limit so timeout stays
    // asserted instead of wrapping around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + TW'(1);
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/gan_layer_scheduler.sv
// ----------------------------------------------------------------------------
// gan_layer_scheduler
//
// Purpose:
//   Top-level sequencer for the generator inference chain. On an accepted
//   request it launches layer 0 with a one-cycle start pulse, waits for that
//   layer's done pulse, launches the next layer one cycle later, and so on.
//   After the last layer finishes it pulses done for one cycle. It also keeps
//   a saturating count of the cycles spent running and, optionally, a
//   per-layer watchdog. There is no data path here.
//
// Build option:
//   GAN_SCHED_WATCHDOG_EN  when defined, a layer that has waited
//                          TIMEOUT_CYCLES without answering moves the
//                          scheduler to ST_ERR and sets the sticky err flag.
//                          When undefined there is no timer, ST_ERR cannot be
//                          reached and err stays 0; a stalled layer keeps the
//                          scheduler running until abort.
//
// Parameters:
//   NUM_LAYERS      number of sequenced layers (2..8)
//   IDX_W           width of cur_layer, at least clog2(NUM_LAYERS)
//   TIMEOUT_CYCLES  watchdog limit per layer (watchdog build only)
//   CNT_W           width of cycle_count
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req          in   run the full chain; only looked at in IDLE / ERR
//   abort        in   synchronous abort back to IDLE, beats req and done
//   layer_done   in   per-layer one-cycle done pulses
//   layer_start  out  one-hot one-cycle start pulses
//   busy         out  chain is running
//   done         out  one-cycle pulse after the last layer completes
//   err          out  sticky watchdog error, cleared by the next accepted req
//   cur_layer    out  index of the running layer, 0 when idle
//   cycle_count  out  cycles spent running in the last/current run
// ----------------------------------------------------------------------------
module gan_layer_scheduler
    import gan_sched_pkg::*;
#(
    parameter int NUM_LAYERS     = DEFAULT_NUM_LAYERS,
    parameter int IDX_W          = DEFAULT_IDX_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IDX_W-1:0]      cur_layer,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam logic [NUM_LAYERS-1:0] FIRST_START = NUM_LAYERS'(1);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_LAYERS - 1);

    sched_state_t            state;
    sched_state_t            state_next;
    logic [NUM_LAYERS-1:0]   start_next;
    logic                    done_next;
    logic                    busy_next;
    logic                    err_next;
    logic [IDX_W-1:0]        layer_next;
    logic [CNT_W-1:0]        count_next;
    logic                    active_done;
    logic                    stall_timeout;

    // Only the running layer's done bit counts, and not in the cycle its own
    // start pulse is still out: an engine has to take at least one cycle, so
    // a done that coincides with the start is stale and must not advance us.
    always_comb begin
        active_done = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cur_layer == IDX_W'(i)) begin
                active_done = layer_done[i] & ~layer_start[i];
            end
        end
    end

`ifdef GAN_SCHED_WATCHDOG_EN
    // The timer restarts whenever a start pulse is about to be issued, which
    // covers both the initial launch and every layer-to-layer hand-off.
    gan_sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (|start_next),
        .enable (state == ST_RUN),
        .timeout(stall_timeout)
    );
`else
    logic unused_timeout_cfg;

    // Without the watchdog a layer can never time out; the timeout parameter
    // is still referenced here so every build shares one parameter list.
    assign stall_timeout      = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Next-state and next-output logic. Every output is registered, so this
    // block decides what each output will show in the cycle after the edge.
    // abort is checked first everywhere because it beats both req and done.
    // The run counter ticks on every RUN cycle that is not aborted, including
    // the final one that produces done, and sticks at all-ones.
    always_comb begin
        state_next = state;
        start_next = '0;
        done_next  = 1'b0;
        busy_next  = busy;
        err_next   = err;
        layer_next = cur_layer;
        count_next = cycle_count;

        case (state)
            ST_IDLE, ST_ERR: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    layer_next = '0;
                end else if (req) begin
                    state_next = ST_RUN;
                    start_next = FIRST_START;
                    busy_next  = 1'b1;
                    err_next   = 1'b0;
                    layer_next = '0;
                    count_next = '0;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    layer_next = '0;
                end else begin
                    if (cycle_count != '1) begin
                        count_next = cycle_count + CNT_W'(1);
                    end
                    if (active_done) begin
                        if (cur_layer == LAST_IDX) begin
                            state_next = ST_IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            layer_next = '0;
                        end else begin
                            layer_next = cur_layer + IDX_W'(1);
                            start_next = FIRST_START << (cur_layer + IDX_W'(1));
                        end
                    end else if (stall_timeout) begin
                        state_next = ST_ERR;
                        busy_next  = 1'b0;
                        err_next   = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
                layer_next = '0;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, so an
    // interrupted run leaves no stray start pulse behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            layer_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cur_layer   <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            layer_start <= start_next;
            busy        <= busy_next;
            done        <= done_next;
            err         <= err_next;
            cur_layer   <= layer_next;
            cycle_count <= count_next;
        end
    end

endmodule

// File: tb/tb_gan_layer_scheduler.sv
// ----------------------------------------------------------------------------
// tb_gan_layer_scheduler
//
// Purpose:
//   Self-checking bench for gan_layer_scheduler with three layers. A reference
//   model of the chain is stepped on every rising edge and compared with the
//   DUT on every falling edge; directed scenarios add hand-computed literal
//   checks. Simple engine responders answer each start pulse after a
//   programmable delay (0 means never answer).
//   Build with GAN_SCHED_WATCHDOG_EN to run the watchdog scenarios.
// ----------------------------------------------------------------------------
module tb_gan_layer_scheduler;

    localparam int NL = 3;
    localparam int IW = 3;
    localparam int CW = 32;
    localparam int TO = 16;

`ifdef GAN_SCHED_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    typedef struct packed {
        logic          running;
        logic          errored;
        int            layer;
        logic [NL-1:0] start;
        logic          done;
        logic          err;
        logic [CW-1:0] count;
        int            waited;
    } model_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          req      = 1'b0;
    logic          abort    = 1'b0;
    logic [NL-1:0] man_done = '0;
    logic [NL-1:0] resp_done;
    logic [NL-1:0] layer_done;
    logic [NL-1:0] layer_start;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] cur_layer;
    logic [CW-1:0] cycle_count;

    int     checks   = 0;
    int     failures = 0;
    bit     cmp_en   = 1'b0;
    int     delay_cfg [NL];
    int     resp_cnt  [NL];
    model_t m;

    assign layer_done = resp_done | man_done;

    always #5 clk = ~clk;

    gan_layer_scheduler #(
        .NUM_LAYERS    (NL),
        .IDX_W         (IW),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .abort      (abort),
        .layer_done (layer_done),
        .layer_start(layer_start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_layer  (cur_layer),
        .cycle_count(cycle_count)
    );

    // Compares one value and records the outcome.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives the bench-controlled inputs for the current cycle.
    task automatic applyStimulus(input logic r, input logic a, input logic [NL-1:0] d);
        req      = r;
        abort    = a;
        man_done = d;
    endtask

    task automatic setDelays(input int d0, input int d1, input int d2);
        delay_cfg[0] = d0;
        delay_cfg[1] = d1;
        delay_cfg[2] = d2;
    endtask

    // Moves to the middle of the next cycle, just after the compare point.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (n) tick();
    endtask

    // One clock of the chain at the level of "which layer is running and how
    // long has it been": an accepted request launches layer 0; a fresh done
    // from the running layer launches the next one or finishes the chain; a
    // layer that has waited the full timeout (watchdog build) is an error.
    function automatic model_t modelStep(input model_t cur, input logic r, input logic a,
                                         input logic [NL-1:0] d);
        model_t        nxt;
        logic [NL-1:0] d_sel;
        logic [NL-1:0] s_sel;
        nxt       = cur;
        nxt.start = '0;
        nxt.done  = 1'b0;
        d_sel     = d >> cur.layer;
        s_sel     = cur.start >> cur.layer;
        if (cur.running) begin
            if (a) begin
                nxt.running = 1'b0;
                nxt.layer   = 0;
            end else begin
                if (cur.count != '1) nxt.count = cur.count + 1;
                if (d_sel[0] && !s_sel[0]) begin
                    if (cur.layer == NL - 1) begin
                        nxt.running = 1'b0;
                        nxt.done    = 1'b1;
                        nxt.layer   = 0;
                    end else begin
                        nxt.layer  = cur.layer + 1;
                        nxt.start  = NL'(1) << (cur.layer + 1);
                        nxt.waited = 0;
                    end
                end else if (WD_ON && cur.waited >= TO) begin
                    nxt.running = 1'b0;
                    nxt.errored = 1'b1;
                    nxt.err     = 1'b1;
                end else begin
                    nxt.waited = cur.waited + 1;
                end
            end
        end else if (a) begin
            nxt.errored = 1'b0;
            nxt.layer   = 0;
        end else if (r) begin
            nxt.running = 1'b1;
            nxt.errored = 1'b0;
            nxt.err     = 1'b0;
            nxt.layer   = 0;
            nxt.start   = NL'(1);
            nxt.count   = '0;
            nxt.waited  = 0;
        end
        return nxt;
    endfunction

    // Reference model advances with the DUT and resets with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= modelStep(m, req, abort, layer_done);
    end

    // Engine stand-ins: each answers its start pulse delay_cfg cycles later.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_done <= '0;
            for (int i = 0; i < NL; i++) resp_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (layer_start[i]) begin
                    resp_cnt[i]  <= delay_cfg[i];
                    resp_done[i] <= 1'b0;
                end else if (resp_cnt[i] > 0) begin
                    resp_cnt[i]  <= resp_cnt[i] - 1;
                    resp_done[i] <= (resp_cnt[i] == 1);
                end else begin
                    resp_done[i] <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, plus the
    // pulse-exclusivity rules that must hold at all times.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            checkOutput("model_layer_start", 64'(layer_start), 64'(m.start));
            checkOutput("model_busy",        64'(busy),        64'(m.running));
            checkOutput("model_done",        64'(done),        64'(m.done));
            checkOutput("model_err",         64'(err),         64'(m.err));
            checkOutput("model_cur_layer",   64'(cur_layer),   64'(m.layer));
            checkOutput("model_cycle_count", 64'(cycle_count), 64'(m.count));
            checkOutput("start_onehot0",     64'($onehot0(layer_start)), 64'(1));
            checkOutput("start_done_excl",   64'(done && (layer_start != '0)), 64'(0));
        end
    end

    initial begin
        setDelays(5, 5, 5);
        applyStimulus(1'b0, 1'b0, '0);
        repeat (3) tick();

        // Reset values while rst_n is held low.
        checkOutput("rst_layer_start", 64'(layer_start), 64'(0));
        checkOutput("rst_busy",        64'(busy),        64'(0));
        checkOutput("rst_cycle_count", 64'(cycle_count), 64'(0));
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        idleCycles(2);

        // Reset mid-run: everything drops at once, nothing restarts.
        $display("[TB] reset during run");
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) applyStimulus(1'b0, 1'b0, '0);
            if (c == 4) begin
                checkOutput("mid_busy_before", 64'(busy), 64'(1));
                rst_n = 1'b0;
                #1;
                checkOutput("mid_rst_start", 64'(layer_start), 64'(0));
                checkOutput("mid_rst_busy",  64'(busy),        64'(0));
                checkOutput("mid_rst_done",  64'(done),        64'(0));
                checkOutput("mid_rst_err",   64'(err),         64'(0));
                checkOutput("mid_rst_layer", 64'(cur_layer),   64'(0));
                checkOutput("mid_rst_count", 64'(cycle_count), 64'(0));
            end
            if (c == 6) rst_n = 1'b1;
            if (c >= 7) checkOutput("post_rst_no_start", 64'(layer_start), 64'(0));
        end
        idleCycles(2);

        // Each layer answers 5 cycles after its start.
        $display("[TB] five-cycle responders");
        setDelays(5, 5, 5);
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1)  applyStimulus(1'b0, 1'b0, '0);
            if (c == 1)  checkOutput("t2_start0", 64'(layer_start), 64'(3'b001));
            if (c == 7)  checkOutput("t2_start1", 64'(layer_start), 64'(3'b010));
            if (c == 13) checkOutput("t2_start2", 64'(layer_start), 64'(3'b100));
            if (c == 18) checkOutput("t2_not_done_yet", 64'(done), 64'(0));
            if (c == 19) begin
                checkOutput("t2_done",        64'(done),        64'(1));
                checkOutput("t2_cycle_count", 64'(cycle_count), 64'(18));
                checkOutput("t2_busy_low",    64'(busy),        64'(0));
            end
        end
        idleCycles(3);

        // Fastest responders: done 2*NL cycles after the request edge.
        $display("[TB] fastest responders");
        setDelays(1, 1, 1);
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) applyStimulus(1'b0, 1'b0, '0);
            if (c == 3) checkOutput("t3_start1", 64'(layer_start), 64'(3'b010));
            if (c == 6) checkOutput("t3_done_early", 64'(done), 64'(0));
            if (c == 7) begin
                checkOutput("t3_done",  64'(done),        64'(1));
                checkOutput("t3_count", 64'(cycle_count), 64'(6));
            end
        end
        idleCycles(3);

        // Stale done during the start cycle and a spurious done for layer 2
        // are both ignored.
        $display("[TB] ignored done pulses");
        setDelays(5, 5, 5);
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) applyStimulus(1'b0, 1'b0, 3'b001);
            if (c == 2) begin
                applyStimulus(1'b0, 1'b0, '0);
                checkOutput("t4_same_cycle_start", 64'(layer_start), 64'(0));
                checkOutput("t4_same_cycle_layer", 64'(cur_layer),   64'(0));
            end
            if (c == 3) applyStimulus(1'b0, 1'b0, 3'b100);
            if (c == 4) applyStimulus(1'b0, 1'b0, '0);
            if (c == 5) checkOutput("t4_spurious_layer", 64'(cur_layer), 64'(0));
            if (c == 7) checkOutput("t4_start1", 64'(layer_start), 64'(3'b010));
            if (c == 19) checkOutput("t4_done", 64'(done), 64'(1));
        end
        idleCycles(3);

        // Abort in the same cycle as layer 0's done.
        $display("[TB] abort with done");
        setDelays(3, 5, 5);
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) applyStimulus(1'b0, 1'b0, '0);
            if (c == 4) begin
                checkOutput("t4b_done0_seen", 64'(layer_done[0]), 64'(1));
                applyStimulus(1'b0, 1'b1, '0);
            end
            if (c == 5) begin
                applyStimulus(1'b0, 1'b0, '0);
                checkOutput("t4b_busy",  64'(busy),        64'(0));
                checkOutput("t4b_count", 64'(cycle_count), 64'(3));
                checkOutput("t4b_layer", 64'(cur_layer),   64'(0));
            end
            if (c >= 5) begin
                checkOutput("t4b_no_start", 64'(layer_start), 64'(0));
                checkOutput("t4b_no_done",  64'(done),        64'(0));
            end
        end

        // abort also blocks a request in IDLE.
        applyStimulus(1'b1, 1'b1, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("idle_abort_blocks_req", 64'(layer_start), 64'(0));
        idleCycles(3);

        // req held high: runs follow each other back to back.
        $display("[TB] back-to-back runs");
        setDelays(1, 1, 1);
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 7)  checkOutput("t6_done1",  64'(done),        64'(1));
            if (c == 8)  checkOutput("t6_start0", 64'(layer_start), 64'(3'b001));
            if (c == 8)  checkOutput("t6_count0", 64'(cycle_count), 64'(0));
            if (c == 14) checkOutput("t6_done2",  64'(done),        64'(1));
            if (c == 15) begin
                checkOutput("t6_start0b", 64'(layer_start), 64'(3'b001));
                applyStimulus(1'b0, 1'b0, '0);
            end
            if (c == 21) checkOutput("t6_done3", 64'(done), 64'(1));
            if (c == 23) checkOutput("t6_stays_idle", 64'(busy), 64'(0));
        end
        idleCycles(3);

`ifdef GAN_SCHED_WATCHDOG_EN
        // Layer 1 never answers: ERR after it waited the full timeout.
        $display("[TB] watchdog timeout");
        setDelays(2, 0, 2);
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 31; c++) begin
            tick();
            if (c == 1) applyStimulus(1'b0, 1'b0, '0);
            if (c == 20) begin
                checkOutput("t5_busy_before", 64'(busy), 64'(1));
                checkOutput("t5_err_before",  64'(err),  64'(0));
            end
            if (c == 21) begin
                checkOutput("t5_err",   64'(err),         64'(1));
                checkOutput("t5_busy",  64'(busy),        64'(0));
                checkOutput("t5_layer", 64'(cur_layer),   64'(1));
                checkOutput("t5_count", 64'(cycle_count), 64'(20));
            end
            if (c == 22) setDelays(1, 1, 1);
            if (c == 23) applyStimulus(1'b1, 1'b0, '0);
            if (c == 24) begin
                applyStimulus(1'b0, 1'b0, '0);
                checkOutput("t5_err_cleared", 64'(err),         64'(0));
                checkOutput("t5_restart",     64'(layer_start), 64'(3'b001));
                checkOutput("t5_restart_lyr", 64'(cur_layer),   64'(0));
            end
            if (c == 30) checkOutput("t5_done", 64'(done), 64'(1));
        end
        idleCycles(3);

        // Abort out of ERR keeps err set until the next accepted request.
        $display("[TB] abort from error");
        setDelays(1, 0, 1);
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (c == 1)  applyStimulus(1'b0, 1'b0, '0);
            if (c == 20) checkOutput("t5b_err", 64'(err), 64'(1));
            if (c == 22) applyStimulus(1'b0, 1'b1, '0);
            if (c == 23) begin
                applyStimulus(1'b0, 1'b0, '0);
                setDelays(1, 1, 1);
                checkOutput("t5b_err_kept", 64'(err),         64'(1));
                checkOutput("t5b_layer",    64'(cur_layer),   64'(0));
                checkOutput("t5b_count",    64'(cycle_count), 64'(19));
            end
            if (c == 24) applyStimulus(1'b1, 1'b0, '0);
            if (c == 25) begin
                applyStimulus(1'b0, 1'b0, '0);
                checkOutput("t5b_err_cleared", 64'(err), 64'(0));
            end
        end
        idleCycles(8);
`else
        // Without the watchdog a silent layer keeps the chain running.
        $display("[TB] stalled layer without watchdog");
        setDelays(1, 0, 1);
        applyStimulus(1'b1, 1'b0, '0);
        for (int c = 1; c <= 43; c++) begin
            tick();
            if (c == 1) applyStimulus(1'b0, 1'b0, '0);
            if (c == 40) begin
                checkOutput("stall_busy",  64'(busy),      64'(1));
                checkOutput("stall_err",   64'(err),       64'(0));
                checkOutput("stall_layer", 64'(cur_layer), 64'(1));
                applyStimulus(1'b0, 1'b1, '0);
            end
            if (c == 41) begin
                applyStimulus(1'b0, 1'b0, '0);
                checkOutput("stall_abort_busy",  64'(busy),        64'(0));
                checkOutput("stall_abort_layer", 64'(cur_layer),   64'(0));
                checkOutput("stall_abort_count", 64'(cycle_count), 64'(39));
            end
        end
        idleCycles(3);
`endif

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
